// File: rtl/stage_fetch_if.sv
// Fetch-stage handshake bundle: instruction memory request/response, decode handoff,
// and the redirect/halt controls coming back from downstream.
interface stage_fetch_if;
    logic        IMemReq;
    logic [15:0] IMemAddr;
    logic        IMemRdy;
    logic [15:0] IMemData;
    logic [15:0] Inst;
    logic [15:0] NextPC;
    logic        InstValid;
    logic        InstReady;
    logic        Redirect;
    logic [15:0] RedirectPC;
    logic        Halt;
    logic        Halted;
    logic        err;

    modport master (
        output IMemReq, IMemAddr, Inst, NextPC, InstValid, Halted, err,
        input  IMemRdy, IMemData, InstReady, Redirect, RedirectPC, Halt
    );

    modport slave (
        input  IMemReq, IMemAddr, Inst, NextPC, InstValid, Halted, err,
        output IMemRdy, IMemData, InstReady, Redirect, RedirectPC, Halt
    );
endinterface

// File: rtl/stage_fetch.sv
// Instruction fetch stage: owns the PC, fetches from a multi-cycle memory and drains
// any request made stale by a redirect or halt instead of withdrawing it.
//   state     | meaning
//   RUN       | normal fetch/deliver
//   DROP      | drain stale response, then resume at pend_pc
//   DROP_HALT | drain stale response, then stop
//   HALT      | stopped until reset
module stage_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic clk,
    input  logic rst,
    stage_fetch_if.master bus
);
    localparam logic [1:0] RUN       = 2'd0;
    localparam logic [1:0] DROP      = 2'd1;
    localparam logic [1:0] DROP_HALT = 2'd2;
    localparam logic [1:0] HALT      = 2'd3;

    logic [1:0]  state;
    logic [15:0] pc;
    logic [15:0] pend_pc;
    logic [15:0] inst;
    logic [15:0] next_pc;
    logic        inst_valid;
    logic        err_q;
    logic        pend;
    logic        req;
    logic        misaligned;
    logic        halt_ev;
    logic        capture;

    assign misaligned = bus.Redirect && bus.RedirectPC[0];
    assign halt_ev    = bus.Halt || misaligned;

    always_comb begin
        req = 1'b0;
        case (state)
            RUN:       req = (!inst_valid || bus.InstReady) && !bus.Redirect && !bus.Halt;
            DROP:      req = 1'b1;
            DROP_HALT: req = 1'b1;
            default:   req = 1'b0;
        endcase
    end

    assign capture = (state == RUN) && req && bus.IMemRdy;

    assign bus.IMemReq   = req;
    assign bus.IMemAddr  = pc;
    assign bus.Inst      = inst;
    assign bus.NextPC    = next_pc;
    assign bus.InstValid = inst_valid;
    assign bus.Halted    = (state == HALT);
    assign bus.err       = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            pc         <= RESET_PC;
            pend_pc    <= RESET_PC;
            inst       <= 16'h0000;
            next_pc    <= 16'h0000;
            inst_valid <= 1'b0;
            err_q      <= 1'b0;
            pend       <= 1'b0;
        end else begin
            // An un-answered request is still owned by memory even if req drops next cycle.
            pend <= req && !bus.IMemRdy;
            if ((state == RUN || state == DROP) && misaligned)
                err_q <= 1'b1;
            case (state)
                RUN: begin
                    if (halt_ev) begin
                        inst_valid <= 1'b0;
                        state      <= pend ? DROP_HALT : HALT;
                    end else if (bus.Redirect) begin
                        inst_valid <= 1'b0;
                        if (pend) begin
                            pend_pc <= bus.RedirectPC;
                            state   <= DROP;
                        end else begin
                            pc <= bus.RedirectPC;
                        end
                    end else if (capture) begin
                        inst       <= bus.IMemData;
                        next_pc    <= pc + 16'd2;
                        pc         <= pc + 16'd2;
                        inst_valid <= 1'b1;
                    end else if (inst_valid && bus.InstReady) begin
                        inst_valid <= 1'b0;
                    end
                end
                DROP: begin
                    if (halt_ev) begin
                        state <= bus.IMemRdy ? HALT : DROP_HALT;
                    end else begin
                        if (bus.Redirect)
                            pend_pc <= bus.RedirectPC;
                        if (bus.IMemRdy) begin
                            pc    <= bus.Redirect ? bus.RedirectPC : pend_pc;
                            state <= RUN;
                        end
                    end
                end
                DROP_HALT: begin
                    if (bus.IMemRdy)
                        state <= HALT;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_stage_fetch.sv
// Directed bench for stage_fetch: wait-state memory model returning 16'h1000+addr and a
// scoreboard of expected Inst/NextPC pairs popped at each decode handshake.
module tb_stage_fetch;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   wait_states;
    int   wcnt;
    bit   mon_en;

    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] npc;
    } exp_t;
    exp_t exp_q[$];

    stage_fetch_if bus ();

    stage_fetch #(.RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.IMemRdy  = bus.IMemReq && (wcnt >= wait_states);
    assign bus.IMemData = 16'h1000 + bus.IMemAddr;

    always @(posedge clk or posedge rst) begin
        if (rst)
            wcnt <= 0;
        else if (bus.IMemRdy)
            wcnt <= 0;
        else if (bus.IMemReq)
            wcnt <= wcnt + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst && bus.InstValid === 1'b1 && bus.InstReady === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0)
            else begin
                failures++;
                $error("FAIL sb_unexpected observed=%h expected=none", bus.Inst);
            end
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_inst", bus.Inst, e.inst);
                chk("sb_nextpc", bus.NextPC, e.npc);
            end
        end
    end

    task automatic push(input logic [15:0] inst, input logic [15:0] npc);
        exp_t e;
        e.inst = inst;
        e.npc  = npc;
        exp_q.push_back(e);
    endtask

    task automatic wait_rdy(input int max);
        int n = 0;
        while (bus.IMemRdy !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("wait_rdy", {15'b0, bus.IMemRdy}, 16'h0001);
    endtask

    task automatic wait_empty(input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("sb_drain", 16'(exp_q.size()), 16'h0000);
    endtask

    task automatic do_reset(input int ws);
        @(posedge clk); #1;
        rst = 1'b1;
        wait_states = ws;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"},  {15'b0, bus.InstValid}, 16'h0000);
        chk({tag, "_inst"},   bus.Inst, 16'h0000);
        chk({tag, "_nextpc"}, bus.NextPC, 16'h0000);
        chk({tag, "_addr"},   bus.IMemAddr, 16'h0000);
        chk({tag, "_halted"}, {15'b0, bus.Halted}, 16'h0000);
        chk({tag, "_err"},    {15'b0, bus.err}, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        mon_en = 1'b0;
        wait_states = 0;
        rst = 1'b1;
        bus.InstReady = 1'b1;
        bus.Redirect = 1'b0;
        bus.RedirectPC = 16'h0000;
        bus.Halt = 1'b0;

        // reset and zero-wait stream with a 3-cycle decode stall
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        for (int i = 0; i < 5; i++)
            push(16'h1000 + 16'(2 * i), 16'(2 * i + 2));
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("first_valid_c0", {15'b0, bus.InstValid}, 16'h0000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("first_valid_c1", {15'b0, bus.InstValid}, 16'h0001);
        chk("stream_inst0", bus.Inst, 16'h1000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stream_inst1", bus.Inst, 16'h1002);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stream_inst2", bus.Inst, 16'h1004);
        @(posedge clk); #1;
        bus.InstReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk("stall_req", {15'b0, bus.IMemReq}, 16'h0000);
            chk("stall_inst", bus.Inst, 16'h1006);
            chk("stall_nextpc", bus.NextPC, 16'h0008);
        end
        @(posedge clk); #1;
        bus.InstReady = 1'b1;
        @(negedge clk);
        chk("stall_release_req", {15'b0, bus.IMemReq}, 16'h0001);
        wait_empty(10);
        @(posedge clk); #1;
        bus.InstReady = 1'b0;
        mon_en = 1'b0;

        // redirect while a 3-wait-state request is outstanding
        bus.InstReady = 1'b1;
        do_reset(3);
        @(negedge clk);
        chk("rd_req_c0", {15'b0, bus.IMemReq}, 16'h0001);
        @(posedge clk); #1;
        bus.Redirect = 1'b1;
        bus.RedirectPC = 16'h0040;
        @(posedge clk); #1;
        bus.Redirect = 1'b0;
        @(negedge clk);
        chk("rd_drop_req", {15'b0, bus.IMemReq}, 16'h0001);
        chk("rd_drop_addr", bus.IMemAddr, 16'h0000);
        wait_rdy(10);
        chk("rd_drain_addr", bus.IMemAddr, 16'h0000);
        push(16'h1040, 16'h0042);
        mon_en = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rd_new_addr", bus.IMemAddr, 16'h0040);
        chk("rd_discard", {15'b0, bus.InstValid}, 16'h0000);
        wait_empty(20);
        @(posedge clk); #1;
        bus.InstReady = 1'b0;
        mon_en = 1'b0;

        // halt with a request outstanding, later redirect ignored
        do_reset(3);
        @(posedge clk); #1;
        bus.Halt = 1'b1;
        @(posedge clk); #1;
        bus.Halt = 1'b0;
        @(negedge clk);
        chk("halt_drain_req", {15'b0, bus.IMemReq}, 16'h0001);
        chk("halt_drain_halted", {15'b0, bus.Halted}, 16'h0000);
        wait_rdy(10);
        chk("halt_at_rdy", {15'b0, bus.Halted}, 16'h0000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("halted", {15'b0, bus.Halted}, 16'h0001);
        chk("halted_req", {15'b0, bus.IMemReq}, 16'h0000);
        @(posedge clk); #1;
        bus.Redirect = 1'b1;
        bus.RedirectPC = 16'h0080;
        @(posedge clk); #1;
        bus.Redirect = 1'b0;
        bus.InstReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt_hold_req", {15'b0, bus.IMemReq}, 16'h0000);
            chk("halt_hold_valid", {15'b0, bus.InstValid}, 16'h0000);
            chk("halt_hold_halted", {15'b0, bus.Halted}, 16'h0001);
            chk("halt_hold_addr", bus.IMemAddr, 16'h0000);
            @(posedge clk); #1;
        end

        // misaligned redirect target
        do_reset(0);
        bus.Redirect = 1'b1;
        bus.RedirectPC = 16'h0013;
        @(posedge clk); #1;
        bus.Redirect = 1'b0;
        @(negedge clk);
        chk("mis_err", {15'b0, bus.err}, 16'h0001);
        chk("mis_halted", {15'b0, bus.Halted}, 16'h0001);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("mis_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mis_restart_addr", bus.IMemAddr, 16'h0000);
        chk("mis_restart_req", {15'b0, bus.IMemReq}, 16'h0001);

        // PC wrap at 16'hFFFE, then async reset mid-wait
        do_reset(0);
        bus.InstReady = 1'b1;
        bus.Redirect = 1'b1;
        bus.RedirectPC = 16'hFFFE;
        push(16'h0FFE, 16'h0000);
        push(16'h1000, 16'h0002);
        mon_en = 1'b1;
        @(posedge clk); #1;
        bus.Redirect = 1'b0;
        @(negedge clk);
        chk("wrap_addr_fffe", bus.IMemAddr, 16'hFFFE);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrap_addr_0000", bus.IMemAddr, 16'h0000);
        chk("wrap_err", {15'b0, bus.err}, 16'h0000);
        chk("wrap_nextpc", bus.NextPC, 16'h0000);
        wait_empty(10);
        @(posedge clk); #1;
        mon_en = 1'b0;
        bus.InstReady = 1'b0;
        wait_states = 3;
        @(posedge clk); #1;
        bus.InstReady = 1'b1;
        @(negedge clk);
        chk("midwait_req", {15'b0, bus.IMemReq}, 16'h0001);
        chk("midwait_valid", {15'b0, bus.InstValid}, 16'h0001);
        chk("midwait_inst", bus.Inst, 16'h1002);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
